warp_fetch_scheduler: RTL and testbench
=======================================

# warp_fetch_scheduler

Per-warp fetch sequencer that shares the single instruction-fetch path among all warps of a core. It holds each warp's PC, thread mask and run state, picks one eligible warp per cycle round-robin, and presents a registered fetch request on the schedule interface consumed by the fetch stage. Decode unlocks and redirects warps; per-warp pending counters bound instruction-buffer occupancy.

## Interface
- NUM_WARPS, 4, warp count (power of 2, ≥2); NW_WIDTH = max(1, log2(NUM_WARPS))
- NUM_THREADS, 4, threads per warp
- PC_BITS, 31, PC width in halfword units (byte address = {PC, 1'b0})
- UUID_WIDTH, 16, instruction tag width
- MAX_PENDING, 2, max fetched-not-popped instructions per warp (≥1)
- RESET_PC, 31'h40000000, warp-0 start PC
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- sched_valid  out  1  fetch request valid
- sched_wid  out  NW_WIDTH  warp id
- sched_PC  out  PC_BITS  fetch PC
- sched_tmask  out  NUM_THREADS  thread mask
- sched_uuid  out  UUID_WIDTH  instruction tag
- sched_ready  in  1  fetch stage accepts
- unlock_valid  in  1  decode releases a warp
- unlock_wid  in  NW_WIDTH  warp to release
- unlock_redirect  in  1  load new PC
- unlock_PC  in  PC_BITS  redirect target
- unlock_tmc  in  1  load new thread mask
- unlock_tmask  in  NUM_THREADS  new mask
- spawn_valid  in  1  activate warps
- spawn_mask  in  NUM_WARPS  warps to activate
- spawn_PC  in  PC_BITS  start PC for spawned warps
- ibuf_pop  in  NUM_WARPS  per-warp instruction-buffer pop
- busy  out  1  any warp active or sched_valid high

## Operation
- Per-warp state: active, stalled, PC, tmask, pending (0..MAX_PENDING).
- Reset: warp 0 active, PC=RESET_PC, tmask=1; others inactive, tmask=0; all stalled=0, pending=0; uuid counter=0; RR pointer=0; sched_valid=0, sched_* data=0; busy=1.
- Eligible(i) = active & ~stalled & pending < MAX_PENDING (from registered state).
- Output register loads when empty (~sched_valid) or firing (sched_valid & sched_ready). Load picks the first eligible warp at or after RR pointer (wrap at NUM_WARPS); none eligible → sched_valid=0.
- On load of warp w: sched_* = {w, PC[w], tmask[w], uuid}; stalled[w]=1; PC[w]+=2 (wraps mod 2^PC_BITS); pending[w]+=1; uuid+=1 (wraps); RR pointer = w+1 mod NUM_WARPS.
- Held request (valid & ~ready): all sched_* stable; no new selection.
- Unlock (wid u, stalled[u]=1): stalled[u]=0; redirect → PC[u]=unlock_PC; tmc → tmask[u]=unlock_tmask; tmc with mask 0 → active[u]=0. Unlock of non-stalled warp: ignored.
- Spawn: for each set bit i with active[i]=0: active=1, stalled=0, PC=spawn_PC, tmask=all ones, pending unchanged. Already-active warps ignored.
- Same-cycle priority per warp: spawn ignored if unlock targets same warp; unlock beats selection (selection uses pre-edge state, so a warp is never both selected and unlocked in one cycle since selected warps are not stalled, unlocked ones are).
- ibuf_pop[i] and load of i in same cycle: pending unchanged. Pop with pending=0: stays 0.
- busy = |active | sched_valid.

## Timing
- State updates on posedge clk; reset acts immediately, any cycle, dropping in-flight request (sched_valid→0).
- Selection latency: warp eligible in cycle t → sched_valid in cycle t+1.
- Unlock in cycle t → warp eligible t+1 → sched_valid t+2.
- Throughput: one request per cycle when ≥1 eligible warp and sched_ready=1.
- Per-warp: at most one request outstanding before unlock; at most MAX_PENDING unpopped.

## Test plan
- Reset, sched_ready=1 → cycle 1: sched_valid=1, wid=0, PC=0x40000000, tmask=0001, uuid=0; then sched_valid=0 until unlock.
- Unlock wid0 redirect PC=0x100 in cycle t → sched_valid at t+2, PC=0x100, uuid=1.
- Spawn mask=1110 PC=0x200, ready=1, unlock each issued warp immediately → wid order 1,2,3,0,... with PCs 0x200 then 0x202; uuids consecutive.
- sched_ready=0 for 5 cycles with valid request → sched_* unchanged all 5 cycles; one fire on release, uuid increments once.
- MAX_PENDING=2, no ibuf_pop, unlock every issue → warp 0 issues twice then stops; one ibuf_pop[0] → one more issue.
- Unlock wid0 tmc tmask=0 (only active warp) → busy=0 next cycle; async reset asserted mid-held-request → sched_valid=0 same cycle, warp 0 restarts at RESET_PC.

Source files
------------

// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch sequencer: tracks PC, thread mask and run state for each warp and
// issues one registered fetch request per cycle, choosing among eligible warps round-robin.
module warp_fetch_scheduler #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 31,
  parameter int UUID_WIDTH  = 16,
  parameter int MAX_PENDING = 2,
  parameter logic [PC_BITS-1:0] RESET_PC = 31'h40000000,
  parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   sched_valid,
  output logic [NW_WIDTH-1:0]    sched_wid,
  output logic [PC_BITS-1:0]     sched_PC,
  output logic [NUM_THREADS-1:0] sched_tmask,
  output logic [UUID_WIDTH-1:0]  sched_uuid,
  input  logic                   sched_ready,
  input  logic                   unlock_valid,
  input  logic [NW_WIDTH-1:0]    unlock_wid,
  input  logic                   unlock_redirect,
  input  logic [PC_BITS-1:0]     unlock_PC,
  input  logic                   unlock_tmc,
  input  logic [NUM_THREADS-1:0] unlock_tmask,
  input  logic                   spawn_valid,
  input  logic [NUM_WARPS-1:0]   spawn_mask,
  input  logic [PC_BITS-1:0]     spawn_PC,
  input  logic [NUM_WARPS-1:0]   ibuf_pop,
  output logic                   busy
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  logic [NUM_WARPS-1:0]   active, stalled, eligible;
  logic [NUM_WARPS-1:0]   sel_hit, unlock_tgt, unlock_hit, spawn_hit;
  logic [PC_BITS-1:0]     pc      [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask   [NUM_WARPS];
  logic [PEND_W-1:0]      pending [NUM_WARPS];
  logic [UUID_WIDTH-1:0]  uuid;
  logic [NW_WIDTH-1:0]    rr_ptr, pick_wid, scan_idx;
  logic                   pick_found, load_en;

  assign load_en = ~sched_valid | sched_ready;
  assign busy    = (|active) | sched_valid;

  // Scan downward from the farthest offset so the warp closest to rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_wid   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++)
      eligible[i] = active[i] & ~stalled[i] & (pending[i] < PEND_W'(MAX_PENDING));
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      scan_idx = rr_ptr + NW_WIDTH'(k);
      if (eligible[scan_idx]) begin
        pick_found = 1'b1;
        pick_wid   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_hit    = '0;
    unlock_tgt = '0;
    unlock_hit = '0;
    spawn_hit  = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      sel_hit[i]    = load_en & pick_found & (pick_wid == NW_WIDTH'(i));
      unlock_tgt[i] = unlock_valid & (unlock_wid == NW_WIDTH'(i));
      unlock_hit[i] = unlock_tgt[i] & stalled[i];
      spawn_hit[i]  = spawn_valid & spawn_mask[i] & ~active[i] & ~unlock_tgt[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        active[i]  <= (i == 0);
        stalled[i] <= 1'b0;
        pc[i]      <= (i == 0) ? RESET_PC : '0;
        tmask[i]   <= (i == 0) ? NUM_THREADS'(1) : '0;
        pending[i] <= '0;
      end
      uuid        <= '0;
      rr_ptr      <= '0;
      sched_valid <= 1'b0;
      sched_wid   <= '0;
      sched_PC    <= '0;
      sched_tmask <= '0;
      sched_uuid  <= '0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (spawn_hit[i]) begin
          active[i]  <= 1'b1;
          stalled[i] <= 1'b0;
          pc[i]      <= spawn_PC;
          tmask[i]   <= '1;
        end else if (unlock_hit[i]) begin
          stalled[i] <= 1'b0;
          if (unlock_redirect) pc[i] <= unlock_PC;
          if (unlock_tmc) begin
            tmask[i] <= unlock_tmask;
            if (unlock_tmask == '0) active[i] <= 1'b0;
          end
        end else if (sel_hit[i]) begin
          stalled[i] <= 1'b1;
          pc[i]      <= pc[i] + PC_BITS'(2);
        end
        // A pop coinciding with an issue to the same warp cancels out.
        if (sel_hit[i] && !ibuf_pop[i])
          pending[i] <= pending[i] + PEND_W'(1);
        else if (!sel_hit[i] && ibuf_pop[i] && pending[i] != '0)
          pending[i] <= pending[i] - PEND_W'(1);
      end
      if (load_en) begin
        sched_valid <= pick_found;
        if (pick_found) begin
          sched_wid   <= pick_wid;
          sched_PC    <= pc[pick_wid];
          sched_tmask <= tmask[pick_wid];
          sched_uuid  <= uuid;
          uuid        <= uuid + UUID_WIDTH'(1);
          rr_ptr      <= pick_wid + NW_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Bench for warp_fetch_scheduler: directed stimulus, a per-warp behavioural model
// compared every cycle, and literal checks pinning key points of the sequence.
module tb_warp_fetch_scheduler;
  localparam int NW = 4, NT = 4, PCB = 31, UW = 16, MAXP = 2, NWW = 2;

  logic clk = 1'b0;
  logic reset;
  logic sched_valid, sched_ready, busy;
  logic [NWW-1:0] sched_wid, unlock_wid;
  logic [PCB-1:0] sched_PC, unlock_PC, spawn_PC;
  logic [NT-1:0] sched_tmask, unlock_tmask;
  logic [UW-1:0] sched_uuid;
  logic unlock_valid, unlock_redirect, unlock_tmc, spawn_valid;
  logic [NW-1:0] spawn_mask, ibuf_pop;

  int tests = 0, fails = 0;

  warp_fetch_scheduler #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PCB), .UUID_WIDTH(UW),
    .MAX_PENDING(MAXP), .RESET_PC(31'h40000000)) dut (
    .clk(clk), .reset(reset), .sched_valid(sched_valid), .sched_wid(sched_wid),
    .sched_PC(sched_PC), .sched_tmask(sched_tmask), .sched_uuid(sched_uuid),
    .sched_ready(sched_ready), .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
    .unlock_redirect(unlock_redirect), .unlock_PC(unlock_PC), .unlock_tmc(unlock_tmc),
    .unlock_tmask(unlock_tmask), .spawn_valid(spawn_valid), .spawn_mask(spawn_mask),
    .spawn_PC(spawn_PC), .ibuf_pop(ibuf_pop), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the warp table and output register.
  bit m_act[NW], m_stl[NW];
  logic [PCB-1:0] m_pc[NW];
  logic [NT-1:0] m_tm[NW];
  int m_pend[NW];
  logic [UW-1:0] m_uuid;
  int m_rr, m_wid;
  bit m_valid;
  logic [PCB-1:0] m_opc;
  logic [NT-1:0] m_otm;
  logic [UW-1:0] m_ouuid;

  task automatic m_reset();
    for (int i = 0; i < NW; i++) begin
      m_act[i] = (i == 0); m_stl[i] = 0; m_pend[i] = 0;
      m_pc[i] = (i == 0) ? 31'h40000000 : '0;
      m_tm[i] = (i == 0) ? 4'b0001 : 4'b0000;
    end
    m_uuid = 0; m_rr = 0; m_valid = 0; m_wid = 0; m_opc = 0; m_otm = 0; m_ouuid = 0;
  endtask

  task automatic m_step();
    bit n_act[NW]; bit n_stl[NW];
    logic [PCB-1:0] n_pc[NW];
    logic [NT-1:0] n_tm[NW];
    int n_pend[NW];
    int sel;
    bit load;
    n_act = m_act; n_stl = m_stl; n_pc = m_pc; n_tm = m_tm; n_pend = m_pend;
    load = !m_valid || sched_ready;
    sel = -1;
    if (load)
      for (int k = 0; k < NW; k++) begin
        int w;
        w = (m_rr + k) % NW;
        if (sel < 0 && m_act[w] && !m_stl[w] && m_pend[w] < MAXP) sel = w;
      end
    if (unlock_valid && m_stl[unlock_wid]) begin
      n_stl[unlock_wid] = 0;
      if (unlock_redirect) n_pc[unlock_wid] = unlock_PC;
      if (unlock_tmc) begin
        n_tm[unlock_wid] = unlock_tmask;
        if (unlock_tmask == 0) n_act[unlock_wid] = 0;
      end
    end
    for (int w = 0; w < NW; w++)
      if (spawn_valid && spawn_mask[w] && !m_act[w] && !(unlock_valid && unlock_wid == w)) begin
        n_act[w] = 1; n_stl[w] = 0; n_pc[w] = spawn_PC; n_tm[w] = '1;
      end
    for (int w = 0; w < NW; w++)
      n_pend[w] = m_pend[w] + ((sel == w) ? 1 : 0)
                  - ((ibuf_pop[w] && (sel == w || m_pend[w] > 0)) ? 1 : 0);
    if (load) begin
      m_valid = (sel >= 0);
      if (sel >= 0) begin
        m_wid = sel; m_opc = m_pc[sel]; m_otm = m_tm[sel]; m_ouuid = m_uuid;
        m_uuid = m_uuid + 1;
        m_rr = (sel + 1) % NW;
        n_stl[sel] = 1;
        n_pc[sel] = m_pc[sel] + 2;
      end
    end
    m_act = n_act; m_stl = n_stl; m_pc = n_pc; m_tm = n_tm; m_pend = n_pend;
  endtask

  always @(posedge clk or posedge reset) begin
    bit any;
    if (reset) m_reset(); else m_step();
    #1;
    any = m_valid;
    for (int i = 0; i < NW; i++) any = any | m_act[i];
    chk("model_valid", sched_valid, m_valid);
    chk("model_busy", busy, any);
    if (m_valid) begin
      chk("model_wid", sched_wid, m_wid);
      chk("model_pc", sched_PC, m_opc);
      chk("model_tmask", sched_tmask, m_otm);
      chk("model_uuid", sched_uuid, m_ouuid);
    end
  end

  int exp_wid[5] = '{1, 2, 3, 0, 1};
  logic [PCB-1:0] exp_pc[5] = '{31'h200, 31'h200, 31'h200, 31'h104, 31'h202};
  int rec_wid[5];
  logic [PCB-1:0] rec_pc[5];
  logic [UW-1:0] rec_uuid[5];

  task automatic clear_in();
    unlock_valid = 0; unlock_wid = 0; unlock_redirect = 0; unlock_PC = 0;
    unlock_tmc = 0; unlock_tmask = 0; spawn_valid = 0; spawn_mask = 0; spawn_PC = 0;
    ibuf_pop = 0;
  endtask

  initial begin
    int n;
    reset = 1; sched_ready = 1; clear_in();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset_issue_valid", sched_valid, 1);
    chk("reset_issue_wid", sched_wid, 0);
    chk("reset_issue_pc", sched_PC, 31'h40000000);
    chk("reset_issue_tmask", sched_tmask, 4'b0001);
    chk("reset_issue_uuid", sched_uuid, 0);
    @(negedge clk);
    chk("stalled_idle", sched_valid, 0);
    unlock_valid = 1; unlock_wid = 0; unlock_redirect = 1; unlock_PC = 31'h100;
    sched_ready = 0;
    @(negedge clk);
    clear_in();
    chk("unlock_plus1_idle", sched_valid, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", sched_valid, 1);
      chk("hold_pc", sched_PC, 31'h100);
      chk("hold_uuid", sched_uuid, 1);
    end
    sched_ready = 1;
    @(negedge clk);
    chk("after_release_idle", sched_valid, 0);
    unlock_valid = 1; unlock_wid = 0;
    @(negedge clk);
    clear_in();
    @(negedge clk);
    chk("pending_full_a", sched_valid, 0);
    @(negedge clk);
    chk("pending_full_b", sched_valid, 0);
    ibuf_pop = 4'b0001;
    @(negedge clk);
    ibuf_pop = 0;
    chk("pop_plus1_idle", sched_valid, 0);
    @(negedge clk);
    chk("pop_issue_valid", sched_valid, 1);
    chk("pop_issue_pc", sched_PC, 31'h102);
    chk("pop_issue_uuid", sched_uuid, 2);
    @(negedge clk);
    ibuf_pop = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    ibuf_pop = 0;
    spawn_valid = 1; spawn_mask = 4'b1110; spawn_PC = 31'h200;
    unlock_valid = 1; unlock_wid = 0;
    @(negedge clk);
    clear_in();
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      if (c > 0) @(negedge clk);
      clear_in();
      if (sched_valid) begin
        rec_wid[n] = sched_wid; rec_pc[n] = sched_PC; rec_uuid[n] = sched_uuid;
        unlock_valid = 1; unlock_wid = sched_wid;
        ibuf_pop = 4'b0001 << sched_wid;
        n++;
      end
    end
    chk("rr_issue_count", n, 5);
    for (int j = 0; j < 5 && j < n; j++) begin
      chk("rr_wid", rec_wid[j], exp_wid[j]);
      chk("rr_pc", rec_pc[j], exp_pc[j]);
      chk("rr_uuid", rec_uuid[j], 3 + j);
    end
    @(negedge clk);
    clear_in();
    repeat (4) @(negedge clk);
    chk("drained_idle", sched_valid, 0);
    for (int w = 0; w < NW; w++) begin
      chk("busy_while_active", busy, 1);
      unlock_valid = 1; unlock_wid = w[NWW-1:0]; unlock_tmc = 1; unlock_tmask = 0;
      @(negedge clk);
    end
    clear_in();
    chk("busy_all_retired", busy, 0);
    spawn_valid = 1; spawn_mask = 4'b0001; spawn_PC = 31'h300; sched_ready = 0;
    @(negedge clk);
    clear_in();
    @(negedge clk);
    chk("respawn_valid", sched_valid, 1);
    chk("respawn_pc", sched_PC, 31'h300);
    chk("respawn_tmask", sched_tmask, 4'b1111);
    chk("respawn_uuid", sched_uuid, 12);
    #2 reset = 1;
    #1;
    chk("async_reset_drop", sched_valid, 0);
    @(negedge clk);
    reset = 0; sched_ready = 1;
    @(negedge clk);
    chk("restart_valid", sched_valid, 1);
    chk("restart_wid", sched_wid, 0);
    chk("restart_pc", sched_PC, 31'h40000000);
    chk("restart_uuid", sched_uuid, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
